// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its helpers.
package lsu_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'b00,
        FC_MISALIGNED = 2'b01,
        FC_RANGE      = 2'b10,
        FC_ILLEGAL    = 2'b11
    } fault_cause_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

    // Number of bytes touched by an access; the illegal encoding is treated as a word.
    function automatic logic [2:0] sizeBytes(input size_e s);
        case (s)
            SZ_BYTE: sizeBytes = 3'd1;
            SZ_HALF: sizeBytes = 3'd2;
            default: sizeBytes = 3'(WORD_BYTES);
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a RAM word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
        o_data = '0;
        case (i_offset)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
        endcase
        case (size_e'(i_size))
            SZ_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            SZ_WORD: o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: validates core accesses, drives the single-port RAM and
// returns aligned load data after the RAM's one-cycle read latency.
module lsu
    import lsu_pkg::*;
#(
    parameter int INSTR_MEM_SIZE = 256,
    parameter int DATA_MEM_SIZE  = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_stall,
    output logic        lsu_fault,
    output logic [1:0]  lsu_fault_cause,
    output logic [31:0] lsu_fault_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);

    localparam logic [32:0] INSTR_END = 33'(INSTR_MEM_SIZE);
    localparam logic [32:0] MEM_END   = 33'(INSTR_MEM_SIZE + DATA_MEM_SIZE);

    lsu_state_e   r_state;
    lsu_state_e   w_nextState;
    size_e        r_size;
    logic         r_unsigned;
    logic [1:0]   r_offset;
    logic [31:0]  r_faultAddr;

    size_e        w_size;
    fault_cause_e w_cause;
    logic         w_issue;
    logic         w_fault;
    logic [32:0]  w_lastByte;
    logic [31:0]  w_alignData;

    assign w_size     = size_e'(lsu_size);
    // Reset gates the request so a held lsu_req cannot reach the RAM while rstn is low.
    assign w_issue    = rstn && lsu_req && (r_state == ST_IDLE);
    assign w_lastByte = {1'b0, lsu_addr} + 33'(sizeBytes(w_size)) - 33'd1;
    assign w_fault    = w_issue && (w_cause != FC_NONE);

    always_comb begin
        w_cause = FC_NONE;
        if (w_size == SZ_ILLEGAL)
            w_cause = FC_ILLEGAL;
        else if ((w_size == SZ_HALF && lsu_addr[0]) ||
                 (w_size == SZ_WORD && lsu_addr[1:0] != 2'b00))
            w_cause = FC_MISALIGNED;
        else if ((w_lastByte >= MEM_END) || (lsu_we && ({1'b0, lsu_addr} < INSTR_END)))
            w_cause = FC_RANGE;
    end

    always_comb begin
        w_nextState     = r_state;
        lsu_stall       = 1'b0;
        lsu_fault       = 1'b0;
        lsu_fault_cause = FC_NONE;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        dmem_be         = 4'b0000;
        dmem_addr       = '0;
        dmem_wdata      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_fault) begin
                    lsu_fault       = 1'b1;
                    lsu_fault_cause = w_cause;
                end else if (w_issue) begin
                    dmem_req  = 1'b1;
                    dmem_we   = lsu_we;
                    dmem_addr = {lsu_addr[31:2], 2'b00};
                    if (lsu_we) begin
                        case (w_size)
                            SZ_BYTE: begin
                                dmem_be    = 4'b0001 << lsu_addr[1:0];
                                dmem_wdata = {4{lsu_wdata[7:0]}};
                            end
                            SZ_HALF: begin
                                dmem_be    = lsu_addr[1] ? 4'b1100 : 4'b0011;
                                dmem_wdata = {2{lsu_wdata[15:0]}};
                            end
                            default: begin
                                dmem_be    = 4'b1111;
                                dmem_wdata = lsu_wdata;
                            end
                        endcase
                    end else begin
                        dmem_be     = 4'b1111;
                        lsu_stall   = 1'b1;
                        w_nextState = ST_WAIT;
                    end
                end
            end
            ST_WAIT: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_offset    <= 2'b00;
            r_faultAddr <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_issue && !w_fault && !lsu_we) begin
                r_size     <= w_size;
                r_unsigned <= lsu_unsigned;
                r_offset   <= lsu_addr[1:0];
            end
            if (w_fault)
                r_faultAddr <= lsu_addr;
        end
    end

    lsu_load_align u_align (
        .i_word     (dmem_rdata),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_alignData)
    );

    assign lsu_rdata      = (r_state == ST_WAIT) ? w_alignData : '0;
    assign lsu_fault_addr = r_faultAddr;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a byte-level memory model predicts every output
// each cycle, and literal expectations from hand-worked examples pin the model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_fault;
    logic [1:0]  lsu_fault_cause;
    logic [31:0] lsu_fault_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    lsu #(.INSTR_MEM_SIZE(256), .DATA_MEM_SIZE(256)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .lsu_req         (lsu_req),
        .lsu_we          (lsu_we),
        .lsu_size        (lsu_size),
        .lsu_unsigned    (lsu_unsigned),
        .lsu_addr        (lsu_addr),
        .lsu_wdata       (lsu_wdata),
        .lsu_rdata       (lsu_rdata),
        .lsu_stall       (lsu_stall),
        .lsu_fault       (lsu_fault),
        .lsu_fault_cause (lsu_fault_cause),
        .lsu_fault_addr  (lsu_fault_addr),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_be         (dmem_be),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata)
    );

    // ramMem is the RAM the DUT drives; modelMem is what the memory should hold.
    logic [31:0] ramMem   [0:127];
    logic [31:0] modelMem [0:127];

    int   nCompared = 0;
    int   nMismatch = 0;
    logic chkEn = 1'b0;

    logic        expStall, expFault, expDreq, expDwe;
    logic [1:0]  expCause;
    logic [3:0]  expBe;
    logic [31:0] expDaddr, expDwdata, expRdata, expFaultAddr;

    logic        pendFault, pendStore, pendLoad;
    logic [31:0] pendAddr, pendWdata;
    int          pendBytes;
    logic        pendUns;

    always @(posedge clk) begin
        if (dmem_req) begin
            if (dmem_we) begin
                for (int b = 0; b < 4; b++)
                    if (dmem_be[b]) ramMem[dmem_addr[8:2]][b*8 +: 8] = dmem_wdata[b*8 +: 8];
            end else begin
                dmem_rdata <= ramMem[dmem_addr[8:2]];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("stall",      32'(lsu_stall),       32'(expStall));
            checkOutput("fault",      32'(lsu_fault),       32'(expFault));
            checkOutput("fault_cause", 32'(lsu_fault_cause), 32'(expCause));
            checkOutput("fault_addr", lsu_fault_addr,       expFaultAddr);
            checkOutput("dmem_req",   32'(dmem_req),        32'(expDreq));
            checkOutput("dmem_we",    32'(dmem_we),         32'(expDwe));
            checkOutput("dmem_be",    32'(dmem_be),         32'(expBe));
            checkOutput("dmem_addr",  dmem_addr,            expDaddr);
            checkOutput("dmem_wdata", dmem_wdata,           expDwdata);
            checkOutput("rdata",      lsu_rdata,            expRdata);
        end
    end

    task automatic clearExp();
        expStall  = 1'b0; expFault = 1'b0; expCause  = 2'b00; expDreq  = 1'b0;
        expDwe    = 1'b0; expBe    = 4'h0; expDaddr  = '0;    expDwdata = '0;
        expRdata  = '0;
    endtask

    // Predict the request cycle from the access rules: size, alignment, address window.
    task automatic modelIssue(input logic req, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        int          nb;
        int          off;
        logic [63:0] endAddr;
        logic [1:0]  cause;
        clearExp();
        pendFault = 1'b0; pendStore = 1'b0; pendLoad = 1'b0;
        if (!req) return;
        nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off     = int'(addr % 4);
        endAddr = 64'(addr) + 64'(nb);
        if (size == 2'd3)                               cause = 2'd3;
        else if (addr % nb != 0)                        cause = 2'd1;
        else if (endAddr > 64'd512 || (we && addr < 256)) cause = 2'd2;
        else                                            cause = 2'd0;
        pendAddr = addr; pendWdata = wdata; pendBytes = nb; pendUns = uns;
        if (cause != 2'd0) begin
            expFault  = 1'b1;
            expCause  = cause;
            pendFault = 1'b1;
        end else begin
            expDreq  = 1'b1;
            expDaddr = addr & ~32'd3;
            if (we) begin
                expDwe    = 1'b1;
                expBe     = 4'(((1 << nb) - 1) << off);
                expDwdata = (nb == 1) ? {24'd0, wdata[7:0]} * 32'h01010101 :
                            (nb == 2) ? {16'd0, wdata[15:0]} * 32'h00010001 : wdata;
                pendStore = 1'b1;
            end else begin
                expBe    = 4'hF;
                expStall = 1'b1;
                pendLoad = 1'b1;
            end
        end
    endtask

    task automatic modelCommit();
        int off;
        off = int'(pendAddr % 4);
        if (pendFault) expFaultAddr = pendAddr;
        if (pendStore)
            for (int b = 0; b < pendBytes; b++)
                modelMem[pendAddr[8:2]][(off + b)*8 +: 8] = pendWdata[b*8 +: 8];
    endtask

    task automatic modelWait();
        logic [31:0] v;
        logic [31:0] mask;
        clearExp();
        v    = modelMem[pendAddr[8:2]] >> (8 * (pendAddr % 4));
        mask = (pendBytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * pendBytes)) - 32'd1);
        v    = v & mask;
        if (!pendUns && pendBytes < 4 && v[8*pendBytes-1]) v = v | ~mask;
        expRdata = v;
    endtask

    // One core access; returns what the DUT showed in the request cycle and in WAIT.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] obsRdata, output logic [31:0] obsBe,
                                 output logic [31:0] obsWdata, output logic [31:0] obsCause);
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
        lsu_addr = addr; lsu_wdata = wdata;
        modelIssue(1'b1, we, size, uns, addr, wdata);
        obsRdata = '0;
        @(negedge clk);
        obsBe    = 32'(dmem_be);
        obsWdata = dmem_wdata;
        obsCause = 32'(lsu_fault_cause);
        @(posedge clk);
        modelCommit();
        #1;
        if (pendLoad) begin
            modelWait();
            @(negedge clk);
            obsRdata = lsu_rdata;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleCycle();
        lsu_req = 1'b0;
        modelIssue(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd, be, wd, cs;
        for (int i = 0; i < 128; i++) begin
            ramMem[i]   = 32'(i) * 32'h01030507 + 32'h5A;
            modelMem[i] = 32'(i) * 32'h01030507 + 32'h5A;
        end
        ramMem[64]   = 32'hDEADBEEF;
        modelMem[64] = 32'hDEADBEEF;
        dmem_rdata   = '0;
        rstn = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 2'd0;
        lsu_unsigned = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        clearExp();
        expFaultAddr = '0;
        pendFault = 1'b0; pendStore = 1'b0; pendLoad = 1'b0;
        pendAddr = '0; pendWdata = '0; pendBytes = 1; pendUns = 1'b0;
        #2;
        chkEn = 1'b1;
        checkOutput("reset_stall",      32'(lsu_stall), 32'd0);
        checkOutput("reset_dmem_req",   32'(dmem_req),  32'd0);
        checkOutput("reset_fault_addr", lsu_fault_addr, 32'd0);
        checkOutput("reset_rdata",      lsu_rdata,      32'd0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        idleCycle();

        applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, be, wd, cs);
        checkOutput("lw_100_be", be, 32'hF);
        checkOutput("lw_100", rd, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, rd, be, wd, cs);
        checkOutput("lb_103", rd, 32'hFFFFFFDE);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, rd, be, wd, cs);
        checkOutput("lbu_103", rd, 32'h000000DE);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rd, be, wd, cs);
        checkOutput("lh_102", rd, 32'hFFFFDEAD);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, rd, be, wd, cs);
        checkOutput("lhu_100", rd, 32'h0000BEEF);

        applyStimulus(1'b1, 2'd0, 1'b0, 32'h101, 32'h12, rd, be, wd, cs);
        checkOutput("sb_101_be", be, 32'h2);
        checkOutput("sb_101_wdata", wd, 32'h12121212);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h102, 32'hABCD, rd, be, wd, cs);
        checkOutput("sh_102_be", be, 32'hC);
        checkOutput("sh_102_wdata", wd, 32'hABCDABCD);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, be, wd, cs);
        checkOutput("lw_100_after_stores", rd, 32'hABCD12EF);

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h1FC, 32'h11223344, rd, be, wd, cs);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0, rd, be, wd, cs);
        checkOutput("lw_1fc", rd, 32'h11223344);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h1FE, 32'h8001, rd, be, wd, cs);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h1FE, 32'h0, rd, be, wd, cs);
        checkOutput("lh_1fe", rd, 32'hFFFF8001);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h005, 32'h0, rd, be, wd, cs);

        applyStimulus(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, rd, be, wd, cs);
        checkOutput("lw_102_cause", cs, 32'd1);
        checkOutput("lw_102_fault_addr", lsu_fault_addr, 32'h102);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h010, 32'h5, rd, be, wd, cs);
        checkOutput("sw_010_cause", cs, 32'd2);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, rd, be, wd, cs);
        checkOutput("lw_200_cause", cs, 32'd2);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'h0, rd, be, wd, cs);
        checkOutput("lh_wrap_cause", cs, 32'd2);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h101, 32'h0, rd, be, wd, cs);
        checkOutput("illegal_size_cause", cs, 32'd3);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h011, 32'h0, rd, be, wd, cs);
        checkOutput("sh_011_cause", cs, 32'd1);
        checkOutput("sh_011_fault_addr", lsu_fault_addr, 32'h011);
        idleCycle();

        // Reset lands while the load sits in WAIT with the request still held.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_unsigned = 1'b0;
        lsu_addr = 32'h104; lsu_wdata = '0;
        modelIssue(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        @(negedge clk);
        @(posedge clk);
        modelCommit();
        #1;
        rstn = 1'b0;
        clearExp();
        expFaultAddr = '0;
        #1;
        checkOutput("rst_wait_stall",      32'(lsu_stall), 32'd0);
        checkOutput("rst_wait_dmem_req",   32'(dmem_req),  32'd0);
        checkOutput("rst_wait_fault_addr", lsu_fault_addr, 32'd0);
        checkOutput("rst_wait_rdata",      lsu_rdata,      32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        lsu_req = 1'b0;
        rstn    = 1'b1;
        idleCycle();
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, be, wd, cs);
        checkOutput("lw_after_reset", rd, 32'hABCD12EF);
        idleCycle();

        chkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
